// File: rtl/sicaklik_pkg.sv
// Shared types and constants for the temperature sensor reader.
package sicaklik_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_SHIFT    = 3'd2,
    S_CS_HOLD  = 3'd3,
    S_PROCESS  = 3'd4,
    S_WAIT     = 3'd5
  } state_e;

  localparam int FRAME_BITS = 16;
  localparam int INT_MSB    = 15;
  localparam int INT_LSB    = 8;

  // A floating (pulled-up) or dead sensor line reads back as all ones.
  localparam logic [FRAME_BITS-1:0] SENSOR_FAULT_FRAME = 16'hFFFF;

endpackage

// File: rtl/sicaklik_okuyucu_if.sv
// Serial sensor bus: read-only SPI mode 0 (sck idle low, sample on rise).
interface sicaklik_okuyucu_if;
  logic sck;
  logic cs_n;
  logic sdo;

  modport master (output sck, output cs_n, input sdo);
  modport slave  (input sck, input cs_n, output sdo);
endinterface

// File: rtl/spi_alici.sv
// SPI mode 0 frame receiver: SCK divider, bit counter and shift register.
// A start pulse launches one 16-bit frame; done pulses on the clk edge that
// drives the final sck fall, by which time frame_o is complete.
module spi_alici
  import sicaklik_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  sdo_i,
  output logic                  sck_o,
  output logic                  done_o,
  output logic [FRAME_BITS-1:0] frame_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  logic                  busy_q;
  logic                  sck_q;
  logic [DIV_W-1:0]      div_q;
  logic [BIT_W-1:0]      bit_q;
  logic [FRAME_BITS-1:0] sr_q;
  logic                  half_end;

  assign half_end = busy_q && (div_q == DIV_LAST);
  assign done_o   = half_end && sck_q && (bit_q == BIT_LAST);
  assign sck_o    = sck_q;
  assign frame_o  = sr_q;

  // Half-period divider toggles sck; sample on the rising toggle, count bits on the falling one.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      sck_q  <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      sr_q   <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      sck_q  <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
    end else if (busy_q) begin
      if (half_end) begin
        div_q <= '0;
        sck_q <= ~sck_q;
        if (!sck_q) begin
          sr_q <= {sr_q[FRAME_BITS-2:0], sdo_i};
        end else begin
          bit_q <= bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) busy_q <= 1'b0;
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/sicaklik_okuyucu.sv
// Periodic temperature sensor reader: frames the SPI read with cs_n,
// averages 2**AVG_LOG2 good samples and flags an all-ones (absent) sensor.
module sicaklik_okuyucu
  import sicaklik_pkg::*;
#(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 50_000_000,
  parameter int AVG_LOG2      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  sicaklik_okuyucu_if.master         sensor,
  output logic [7:0]                 sicaklik,
  output logic                       sicaklik_valid,
  output logic                       hata
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD);
  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  state_e                  state_q;
  logic                    cs_n_q;
  logic [DIV_W-1:0]        tcnt_q;
  logic [PER_W-1:0]        per_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    pend_q;
  logic [7:0]              sicaklik_q;
  logic                    valid_q;
  logic                    hata_q;

  logic                    start;
  logic                    done;
  logic                    sck_w;
  logic [FRAME_BITS-1:0]   frame;
  logic signed [7:0]       samp;

  assign start   = (state_q == S_CS_SETUP) && (tcnt_q == DIV_LAST);
  assign samp    = frame[INT_MSB:INT_LSB];
  // 2**AVG_LOG2 is the only count value with the top bit set.
  assign cnt_inc = cnt_q + CNT_W'(1);

  spi_alici #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .sdo_i   (sensor.sdo),
    .sck_o   (sck_w),
    .done_o  (done),
    .frame_o (frame)
  );

  assign sensor.sck     = sck_w;
  assign sensor.cs_n    = cs_n_q;
  assign sicaklik       = sicaklik_q;
  assign sicaklik_valid = valid_q;
  assign hata           = hata_q;

  // Conversion sequencer, period timer, averaging and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cs_n_q     <= 1'b1;
      tcnt_q     <= '0;
      per_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      sicaklik_q <= '0;
      valid_q    <= 1'b0;
      hata_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (per_q != PER_LAST) per_q <= per_q + PER_W'(1);

      // Publish one cycle after PROCESS, so valid lands two cycles after cs_n rise.
      if (pend_q) begin
        sicaklik_q <= 8'(acc_q >>> AVG_LOG2);
        valid_q    <= 1'b1;
        acc_q      <= '0;
        cnt_q      <= '0;
        pend_q     <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_CS_SETUP;
            cs_n_q  <= 1'b0;
            tcnt_q  <= '0;
          end
        end
        S_CS_SETUP: begin
          if (tcnt_q == DIV_LAST) state_q <= S_SHIFT;
          else                    tcnt_q  <= tcnt_q + DIV_W'(1);
        end
        S_SHIFT: begin
          if (done) begin
            state_q <= S_CS_HOLD;
            tcnt_q  <= '0;
          end
        end
        S_CS_HOLD: begin
          if (tcnt_q == DIV_LAST) begin
            state_q <= S_PROCESS;
            cs_n_q  <= 1'b1;
            // Period is measured from this edge; the first cycle after it counts as 1.
            per_q   <= PER_W'(1);
          end else begin
            tcnt_q <= tcnt_q + DIV_W'(1);
          end
        end
        S_PROCESS: begin
          if (frame == SENSOR_FAULT_FRAME) begin
            hata_q <= 1'b1;
          end else begin
            hata_q <= 1'b0;
            acc_q  <= acc_q + ACC_W'(samp);
            cnt_q  <= cnt_inc;
            if (cnt_inc[AVG_LOG2]) pend_q <= 1'b1;
          end
          state_q <= enable ? S_WAIT : S_IDLE;
        end
        S_WAIT: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end else if (per_q == PER_LAST) begin
            state_q <= S_CS_SETUP;
            cs_n_q  <= 1'b0;
            tcnt_q  <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sicaklik_okuyucu.sv
// Bench for sicaklik_okuyucu: behavioural SPI sensor plus a frame-level
// reference (average of groups of four good readings, floor division).
module tb_sicaklik_okuyucu;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] sicaklik;
  logic       sicaklik_valid;
  logic       hata;

  sicaklik_okuyucu_if sen ();

  sicaklik_okuyucu #(
    .CLK_DIV       (2),
    .SAMPLE_PERIOD (20),
    .AVG_LOG2      (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .sensor         (sen),
    .sicaklik       (sicaklik),
    .sicaklik_valid (sicaklik_valid),
    .hata           (hata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // sensor + reference model state
  logic [15:0] fq[$];
  logic [15:0] cur = 16'h0;
  int  bi = 0, sck_cnt = 0, cyc = 0, fall_cyc = 0, rise_cyc = -1, n_rise = 0;
  int  hcd = 0, vcd = 0, sum = 0, nval = 0, q;
  byte b;
  bit  en_all = 0, csn_prev = 1, sck_prev = 0, rst_edge = 0;
  bit  exp_valid = 0, exp_hata = 0, nh = 0;
  logic [7:0] exp_sic = 8'h0, navg = 8'h0;

  always @(posedge clk) rst_edge = reset;

  // Monitor, sensor model and reference, all sampled mid-cycle.
  always @(negedge clk) begin
    exp_valid = 0;
    if (rst_edge) begin
      sum = 0; nval = 0; exp_sic = 8'h0; exp_hata = 0; hcd = 0; vcd = 0;
      en_all = 0; rise_cyc = -1;
      chk("rst_sck", 32'(sen.sck), 32'd0);
      chk("rst_csn", 32'(sen.cs_n), 32'd1);
    end else begin
      if (hcd > 0) begin hcd--; if (hcd == 0) exp_hata = nh; end
      if (vcd > 0) begin vcd--; if (vcd == 0) begin exp_valid = 1; exp_sic = navg; end end
      if (!csn_prev && sen.cs_n) begin
        chk("sck_rises", 32'(sck_cnt), 32'd16);
        chk("cs_low_width", 32'(cyc - fall_cyc), 32'd68);
        if (cur == 16'hFFFF) nh = 1;
        else begin
          nh = 0; b = cur[15:8]; sum += b; nval++;
          if (nval == 4) begin
            q = sum / 4;
            if (sum < 0 && (sum % 4) != 0) q--;
            navg = q[7:0]; sum = 0; nval = 0; vcd = 2;
          end
        end
        hcd = 1; rise_cyc = cyc; en_all = 1; n_rise++;
      end
      if (csn_prev && !sen.cs_n) begin
        if (en_all && rise_cyc >= 0) chk("period", 32'(cyc - rise_cyc), 32'd20);
        fall_cyc = cyc; sck_cnt = 0;
        cur = (fq.size() > 0) ? fq.pop_front() : 16'($urandom);
        bi = 15; sen.sdo = cur[15];
      end
      if (!sen.cs_n && !sck_prev && sen.sck) sck_cnt++;
      if (!sen.cs_n && sck_prev && !sen.sck && bi > 0) begin bi--; sen.sdo = cur[bi]; end
      if (!enable) en_all = 0;
    end
    chk("hata", 32'(hata), 32'(exp_hata));
    chk("valid", 32'(sicaklik_valid), 32'(exp_valid));
    chk("sicaklik", 32'(sicaklik), 32'(exp_sic));
    csn_prev = sen.cs_n; sck_prev = sen.sck; cyc++;
  end

  task automatic wait_rises(input int k);
    int tgt = n_rise + k;
    int t = 0;
    while (n_rise < tgt && t < k * 400) begin @(posedge clk); t++; end
    if (n_rise < tgt) chk("rise_timeout", 32'(n_rise), 32'(tgt));
  endtask

  task automatic wait_sck(input int k);
    int t = 0;
    while (!(!sen.cs_n && sck_cnt >= k) && t < 400) begin @(posedge clk); t++; end
    if (t >= 400) chk("sck_timeout", 32'(sck_cnt), 32'(k));
  endtask

  logic [15:0] f;

  initial begin
    sen.sdo = 1'b0;
    reset = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0; enable = 1'b1;

    // 1: reset in the middle of a shift
    wait_sck(5);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("t1_csn", 32'(sen.cs_n), 32'd1);
    chk("t1_sck", 32'(sen.sck), 32'd0);
    chk("t1_sic", 32'(sicaklik), 32'd0);
    foreach (fq[i]) fq.delete(i);
    fq = '{16'h1900, 16'h1900, 16'h1900, 16'h1900,
           16'hFF80, 16'hFE00, 16'hFF00, 16'hFE00,
           16'h1E00, 16'hFFFF, 16'h1E00, 16'h1F00, 16'h1F00};
    @(negedge clk) reset = 1'b0;

    // 2: four readings of 25
    wait_rises(4);
    repeat (3) @(negedge clk);
    chk("t2_avg25", 32'(sicaklik), 32'h19);
    // 3: -1,-2,-1,-2 averages to floor(-1.5)
    wait_rises(4);
    repeat (3) @(negedge clk);
    chk("t3_avg_neg", 32'(sicaklik), 32'hFE);
    // 4: fault frame is flagged and skipped
    wait_rises(2);
    repeat (2) @(negedge clk);
    chk("t4_hata_set", 32'(hata), 32'd1);
    wait_rises(1);
    repeat (2) @(negedge clk);
    chk("t4_hata_clr", 32'(hata), 32'd0);
    wait_rises(2);
    repeat (3) @(negedge clk);
    chk("t4_avg30", 32'(sicaklik), 32'h1E);

    // 5: enable dropped mid-frame
    wait_sck(3);
    @(negedge clk) enable = 1'b0;
    wait_rises(1);
    for (int i = 0; i < 6; i++) begin
      repeat (10) @(negedge clk);
      chk("t5_idle_csn", 32'(sen.cs_n), 32'd1);
    end
    @(negedge clk) enable = 1'b1;
    @(posedge clk); #1;
    chk("t5_reen_csn", 32'(sen.cs_n), 32'd0);

    // random frames, occasional enable drops
    for (int i = 0; i < 24; i++) begin
      f = 16'($urandom);
      if ($urandom_range(0, 5) == 0) f = 16'hFFFF;
      fq.push_back(f);
    end
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 60)) @(negedge clk);
        enable = 1'b0;
        repeat ($urandom_range(2, 40)) @(negedge clk);
        enable = 1'b1;
      end
      wait_rises(1);
    end
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

endmodule
